// File: rtl/stereo_half_split_pkg.sv
// rtl/stereo_half_split_pkg.sv - shared constants and helpers for the stereo half-line splitter
//
// Purpose: split-path latency, default geometry and the column-counter width helper,
//          shared with the disparity stage so it can align its sync signals.
// Ports:   none (package).

package stereo_half_split_pkg;

    // Cycles from a right-half input pixel to the matching output column.
    localparam int SPLIT_LATENCY = 2;

    localparam int DEF_PX_WIDTH   = 8;
    localparam int DEF_HALF_IMG_W = 200;
    localparam int DEF_CHANNELS   = 1;

    // Column counter must reach 2*half_w inclusive (it saturates there).
    function automatic int col_width(input int half_w);
        return $clog2(2 * half_w + 1);
    endfunction

    // Line RAM address width; never below one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stereo_half_split_line_ram.sv
// rtl/stereo_half_split_line_ram.sv - simple dual-port line buffer holding the left half line
//
// Purpose: stores the left half of a line so each left pixel can be replayed alongside
//          the right pixel of the same column.
// Ports:   clk          clock
//          we, waddr    write enable / address (left-half column)
//          wdata        pixel to store
//          re, raddr    read enable / address (right-half column minus half width)
//          rdata        registered read data, valid the cycle after re

module stereo_half_split_line_ram
    import stereo_half_split_pkg::*;
#(
    parameter int DEPTH = DEF_HALF_IMG_W,
    parameter int WIDTH = DEF_PX_WIDTH,
    parameter int AW    = addr_width(DEF_HALF_IMG_W)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write and read never target the same address in one cycle: the left half
    // is fully written before the right half starts reading it back.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/stereo_half_split.sv
// rtl/stereo_half_split.sv - splits a side-by-side stereo line into column-aligned L/R streams
//
// Purpose: left half of each line goes into a line RAM; while the right half arrives the
//          left pixel of the same column is read back and both leave together.
//          Frame-synchronous L/R swap, line-length checking and arming after reset.
// Ports:   clk, rst_n                 pixel clock, async active-low reset
//          de_in, h_sync_in, v_sync_in input timing
//          pixel_in                   side-by-side input pixel
//          swap                       exchange outputs, taken at v_sync_in rise
//          clk_out                    clk pass-through
//          de_out                     one pulse per output column
//          h_sync_out, v_sync_out     input syncs delayed by SPLIT_LATENCY
//          pixel_left, pixel_right    column-aligned views, held while de_out=0
//          line_err                   one-cycle pulse for a line of wrong length
//          frame_err                  sticky line error, cleared at v_sync_in rise

module stereo_half_split
    import stereo_half_split_pkg::*;
#(
    parameter int HALF_IMG_W = DEF_HALF_IMG_W,
    parameter int PX_WIDTH   = DEF_PX_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         de_in,
    input  logic                         h_sync_in,
    input  logic                         v_sync_in,
    input  logic [CHANNELS*PX_WIDTH-1:0] pixel_in,
    input  logic                         swap,
    output logic                         clk_out,
    output logic                         de_out,
    output logic                         h_sync_out,
    output logic                         v_sync_out,
    output logic [CHANNELS*PX_WIDTH-1:0] pixel_left,
    output logic [CHANNELS*PX_WIDTH-1:0] pixel_right,
    output logic                         line_err,
    output logic                         frame_err
);

    localparam int DW = CHANNELS * PX_WIDTH;
    localparam int CW = col_width(HALF_IMG_W);
    localparam int AW = addr_width(HALF_IMG_W);

    localparam logic [CW-1:0] HALF = CW'(HALF_IMG_W);
    localparam logic [CW-1:0] FULL = CW'(2 * HALF_IMG_W);

    // Column counter and line-length tracking
    logic [CW-1:0] col;
    logic          col_ovf;     // de_in seen after col saturated: line too long
    logic          de_q;
    logic          v_sync_q;

    // Frame state
    logic          armed;
    logic          swap_q;

    // Split pipeline
    logic          rd_valid;
    logic [DW-1:0] right_q;
    logic [DW-1:0] ram_rdata;

    logic [SPLIT_LATENCY-1:0] hs_d;
    logic [SPLIT_LATENCY-1:0] vs_d;

    logic          de_fall;
    logic          vs_rise;
    logic          in_left;
    logic          in_right;
    logic          line_bad;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    assign clk_out = clk;

    always_comb begin
        de_fall  = de_q & ~de_in;
        vs_rise  = v_sync_in & ~v_sync_q;
        in_left  = de_in && (col < HALF);
        in_right = de_in && (col >= HALF) && (col < FULL);
        // At the falling edge col holds the number of de cycles (saturated);
        // col_ovf distinguishes an exact line from a longer one.
        line_bad = de_fall && ((col != FULL) || col_ovf);
        waddr    = AW'(col);
        raddr    = AW'(col - HALF);
    end

    stereo_half_split_line_ram #(
        .DEPTH (HALF_IMG_W),
        .WIDTH (DW),
        .AW    (AW)
    ) u_line_ram (
        .clk   (clk),
        .we    (in_left),
        .waddr (waddr),
        .wdata (pixel_in),
        .re    (in_right),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            col_ovf <= 1'b0;
        end else if (de_fall) begin
            col     <= '0;
            col_ovf <= 1'b0;
        end else if (de_in) begin
            if (col != FULL) begin
                col <= col + CW'(1);
            end else begin
                col_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q      <= 1'b0;
            v_sync_q  <= 1'b0;
            armed     <= 1'b0;
            swap_q    <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            de_q     <= de_in;
            v_sync_q <= v_sync_in;
            if (vs_rise) begin
                armed  <= 1'b1;
                swap_q <= swap;
            end
            line_err <= line_bad;
            // A line error landing on the frame boundary belongs to the new frame.
            if (line_bad) begin
                frame_err <= 1'b1;
            end else if (vs_rise) begin
                frame_err <= 1'b0;
            end
        end
    end

    // Stage 1 lines up the incoming right pixel with the RAM read; stage 2 registers outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid    <= 1'b0;
            right_q     <= '0;
            de_out      <= 1'b0;
            pixel_left  <= '0;
            pixel_right <= '0;
        end else begin
            rd_valid <= in_right & armed;
            if (in_right) begin
                right_q <= pixel_in;
            end
            de_out <= rd_valid;
            if (rd_valid) begin
                pixel_left  <= swap_q ? right_q   : ram_rdata;
                pixel_right <= swap_q ? ram_rdata : right_q;
            end
        end
    end

    // Syncs follow the data latency whether or not the block is armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d <= '0;
            vs_d <= '0;
        end else begin
            hs_d <= {hs_d[SPLIT_LATENCY-2:0], h_sync_in};
            vs_d <= {vs_d[SPLIT_LATENCY-2:0], v_sync_in};
        end
    end

    assign h_sync_out = hs_d[SPLIT_LATENCY-1];
    assign v_sync_out = vs_d[SPLIT_LATENCY-1];

endmodule

// File: tb/tb_stereo_half_split.sv
// tb/tb_stereo_half_split.sv - self-checking bench for stereo_half_split

module tb_stereo_half_split;

    localparam int H  = 4;
    localparam int PW = 8;
    localparam int CH = 3;
    localparam int DW = PW * CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          de_in = 1'b0;
    logic          h_sync_in = 1'b0;
    logic          v_sync_in = 1'b0;
    logic [DW-1:0] pixel_in = '0;
    logic          swap = 1'b0;
    logic          clk_out;
    logic          de_out;
    logic          h_sync_out;
    logic          v_sync_out;
    logic [DW-1:0] pixel_left;
    logic [DW-1:0] pixel_right;
    logic          line_err;
    logic          frame_err;

    stereo_half_split #(
        .HALF_IMG_W (H),
        .PX_WIDTH   (PW),
        .CHANNELS   (CH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .de_in       (de_in),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .pixel_in    (pixel_in),
        .swap        (swap),
        .clk_out     (clk_out),
        .de_out      (de_out),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .pixel_left  (pixel_left),
        .pixel_right (pixel_right),
        .line_err    (line_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: counts de cycles of the current line, remembers left pixels by
    // column, and predicts what must leave the block after the two-cycle split latency.
    int            m_cnt    = 0;
    bit            m_prev_de = 0;
    bit            m_prev_vs = 0;
    bit            m_armed  = 0;
    bit            m_swap   = 0;
    bit            m_ferr   = 0;
    logic [DW-1:0] m_lb [H];
    // Inputs captured at the previous edge, waiting to emerge
    bit            h_valid = 0, h_hs = 0, h_vs = 0;
    logic [DW-1:0] h_l = '0, h_r = '0;
    // Expected outputs
    bit            e_de = 0, e_hs = 0, e_vs = 0, e_lerr = 0, e_ferr = 0;
    logic [DW-1:0] e_l = '0, e_r = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_prev_de = 0; m_prev_vs = 0;
            m_armed = 0; m_swap = 0; m_ferr = 0;
            h_valid = 0; h_hs = 0; h_vs = 0; h_l = '0; h_r = '0;
            e_de = 0; e_hs = 0; e_vs = 0; e_lerr = 0; e_ferr = 0; e_l = '0; e_r = '0;
        end else begin
            bit vsrise, fell, is_right;
            vsrise   = v_sync_in && !m_prev_vs;
            fell     = !de_in && m_prev_de;
            is_right = de_in && m_cnt >= H && m_cnt < 2 * H;
            // The column sampled one edge ago leaves now, oriented by the current frame's swap.
            e_de = h_valid;
            e_hs = h_hs;
            e_vs = h_vs;
            if (h_valid) begin
                e_l = m_swap ? h_r : h_l;
                e_r = m_swap ? h_l : h_r;
            end
            h_valid = is_right && m_armed;
            h_l     = is_right ? m_lb[m_cnt - H] : '0;
            h_r     = pixel_in;
            h_hs    = h_sync_in;
            h_vs    = v_sync_in;
            e_lerr  = fell && (m_cnt != 2 * H);
            if (e_lerr)      m_ferr = 1;
            else if (vsrise) m_ferr = 0;
            e_ferr = m_ferr;
            if (de_in && m_cnt < H) m_lb[m_cnt] = pixel_in;
            if (fell)       m_cnt = 0;
            else if (de_in) m_cnt = m_cnt + 1;
            if (vsrise) begin
                m_armed = 1;
                m_swap  = swap;
            end
            m_prev_de = de_in;
            m_prev_vs = v_sync_in;
        end
    end

    // Captured output columns for the directed checks
    logic [DW-1:0] cap_l[$];
    logic [DW-1:0] cap_r[$];
    int            lerr_cnt = 0;
    int            first_de_cyc = -1;
    int            drv_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        checks++;
        if (de_out !== e_de || h_sync_out !== e_hs || v_sync_out !== e_vs ||
            line_err !== e_lerr || frame_err !== e_ferr ||
            pixel_left !== e_l || pixel_right !== e_r || clk_out !== clk) begin
            failures++;
            $display("FAIL cycle_model cyc=%0d got de=%b hs=%b vs=%b le=%b fe=%b l=%h r=%h want de=%b hs=%b vs=%b le=%b fe=%b l=%h r=%h",
                     cyc, de_out, h_sync_out, v_sync_out, line_err, frame_err, pixel_left, pixel_right,
                     e_de, e_hs, e_vs, e_lerr, e_ferr, e_l, e_r);
        end
        if (de_out) begin
            cap_l.push_back(pixel_left);
            cap_r.push_back(pixel_right);
            if (first_de_cyc < 0) first_de_cyc = cyc;
        end
        if (line_err) lerr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_capture();
        cap_l = {};
        cap_r = {};
        lerr_cnt = 0;
        first_de_cyc = -1;
    endtask

    task automatic vsync_pulse();
        v_sync_in = 1'b1;
        tick(); tick();
        v_sync_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_line(input logic [DW-1:0] px[$], input bit vs_mid);
        for (int i = 0; i < px.size(); i++) begin
            de_in    = 1'b1;
            pixel_in = px[i];
            if (vs_mid && i == 1) v_sync_in = 1'b1;
            // This cycle is labelled cyc+1 by its falling-edge sample.
            if (i == H) drv_cyc = cyc + 1;
            tick();
        end
        de_in     = 1'b0;
        v_sync_in = 1'b0;
        h_sync_in = 1'b1;
        tick();
        h_sync_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_pairs(input string name, input logic [DW-1:0] el[$], input logic [DW-1:0] er[$]);
        check({name, "_count"}, cap_l.size(), el.size());
        for (int i = 0; i < el.size() && i < cap_l.size(); i++) begin
            check({name, "_left"},  cap_l[i], el[i]);
            check({name, "_right"}, cap_r[i], er[i]);
        end
    endtask

    logic [DW-1:0] q[$];
    logic [DW-1:0] el[$];
    logic [DW-1:0] er[$];

    initial begin
        tick(); tick();
        check("reset_de_out", de_out, 0);
        check("reset_pixels", {pixel_left, pixel_right} == '0, 1);
        check("reset_errs", {line_err, frame_err}, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // 1: basic split and latency
        vsync_pulse();
        clear_capture();
        q = {10, 11, 12, 13, 20, 21, 22, 23};
        send_line(q, 0);
        el = {10, 11, 12, 13}; er = {20, 21, 22, 23};
        check_pairs("t1", el, er);
        check("t1_latency", first_de_cyc - drv_cyc, 2);
        check("t1_line_err", lerr_cnt, 0);

        // 2: swap changed mid-frame waits for the next frame
        swap = 1'b1;
        clear_capture();
        send_line(q, 0);
        check_pairs("t2_same_frame", el, er);
        vsync_pulse();
        clear_capture();
        send_line(q, 0);
        check_pairs("t2_swapped", er, el);

        // 3: short line
        swap = 1'b0;
        vsync_pulse();
        clear_capture();
        q = {1, 2, 3, 4, 5, 6};
        send_line(q, 0);
        el = {1, 2}; er = {5, 6};
        check_pairs("t3", el, er);
        check("t3_line_err", lerr_cnt, 1);
        check("t3_frame_err_set", frame_err, 1);
        vsync_pulse();
        check("t3_frame_err_clr", frame_err, 0);

        // 4: long line
        clear_capture();
        q = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        send_line(q, 0);
        el = {1, 2, 3, 4}; er = {5, 6, 7, 8};
        check_pairs("t4", el, er);
        check("t4_line_err", lerr_cnt, 1);

        // 5: reset mid-line, release mid-line
        vsync_pulse();
        clear_capture();
        de_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pixel_in = DW'(40 + i);
            if (i == 2) rst_n = 1'b0;
            if (i == 4) rst_n = 1'b1;
            tick();
        end
        de_in = 1'b0;
        repeat (4) tick();
        q = {10, 11, 12, 13, 20, 21, 22, 23};
        send_line(q, 0);
        check("t5_no_output_unarmed", cap_l.size(), 0);
        vsync_pulse();
        send_line(q, 0);
        el = {10, 11, 12, 13}; er = {20, 21, 22, 23};
        check_pairs("t5_after_vsync", el, er);

        // 6: full-width multi-channel pixels
        clear_capture();
        q = {24'hAABBCC, 24'hAABBCC, 24'hAABBCC, 24'hAABBCC,
             24'h112233, 24'h112233, 24'h112233, 24'h112233};
        send_line(q, 0);
        el = {24'hAABBCC, 24'hAABBCC, 24'hAABBCC, 24'hAABBCC};
        er = {24'h112233, 24'h112233, 24'h112233, 24'h112233};
        check_pairs("t6", el, er);

        // Randomised lines against the model
        for (int ln = 0; ln < 40; ln++) begin
            int len;
            int pick;
            if (ln % 4 == 0) vsync_pulse();
            if ($urandom_range(0, 3) == 0) swap = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 7);
            case (pick)
                0:       len = 2 * H - 1;
                1:       len = 2 * H + 2;
                2:       len = H + 1;
                3:       len = 3;
                default: len = 2 * H;
            endcase
            q = {};
            for (int i = 0; i < len; i++) q.push_back(DW'($urandom()));
            send_line(q, $urandom_range(0, 7) == 0);
        end
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $finish;
    end

endmodule
